proto245_tx_arb: RTL and testbench

Round-robin scheduler that shares the single TX FIFO write port of the FT245 protocol master between CH_N independent byte-stream requesters. Each granted requester sends a burst of known length. The block prefixes every burst with one header word {channel, length-1}, so the host can demultiplex the USB stream. It sits in the fifo_clk domain and drives txfifo_data/txfifo_wr directly, honouring txfifo_full.

---
 rtl/proto245_pkg.sv | 20 ++
 rtl/proto245_tx_arb_rr_arbiter.sv | 30 +++
 rtl/proto245_tx_arb.sv | 114 +++++++++++
 tb/tb_proto245_tx_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proto245_pkg.sv
// rtl/proto245_pkg.sv - shared types and header packing for the FT245 TX scheduler
package proto245_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } tx_arb_state_t;

    // Header word: channel above the length-1 field, zero-extended by the caller's cast.
    function automatic logic [31:0] hdr_pack(input logic [31:0] ch, input logic [31:0] len_m1,
                                             input int ch_w, input int len_w);
        logic [31:0] ch_mask;
        logic [31:0] len_mask;
        ch_mask  = (32'd1 << ch_w) - 32'd1;
        len_mask = (32'd1 << len_w) - 32'd1;
        return ((ch & ch_mask) << len_w) | (len_m1 & len_mask);
    endfunction

endpackage

// File: rtl/proto245_tx_arb_rr_arbiter.sv
// rtl/proto245_tx_arb_rr_arbiter.sv - combinational round-robin pick starting after last_ch
module rr_arbiter #(
    parameter int CH_N = 4,
    parameter int CH_W = $clog2(CH_N)
) (
    input  logic [CH_N-1:0] req,
    input  logic [CH_W-1:0] last_ch,
    output logic [CH_N-1:0] gnt,
    output logic [CH_W-1:0] idx
);

    int  cand;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 1; i <= CH_N; i++) begin
            cand = (int'(last_ch) + i) % CH_N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = CH_W'(cand);
            end
        end
    end

endmodule

// File: rtl/proto245_tx_arb.sv
// rtl/proto245_tx_arb.sv - round-robin burst scheduler onto the FT245 TX FIFO write port
module proto245_tx_arb
    import proto245_pkg::*;
#(
    parameter int CH_N   = 4,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int CH_W   = $clog2(CH_N)
) (
    input  logic                     fifo_clk,
    input  logic                     fifo_rstn,
    input  logic [CH_N-1:0]          ch_req,
    input  logic [CH_N*LEN_W-1:0]    ch_len,
    input  logic [CH_N*DATA_W-1:0]   ch_data,
    input  logic [CH_N-1:0]          ch_valid,
    output logic [CH_N-1:0]          ch_ready,
    output logic [CH_N-1:0]          ch_gnt,
    output logic [DATA_W-1:0]        txfifo_data,
    output logic                     txfifo_wr,
    input  logic                     txfifo_full,
    output logic                     busy,
    output logic [CH_W-1:0]          cur_ch
);

    if (CH_W + LEN_W > DATA_W) begin : g_bad_cfg
        $error("proto245_tx_arb: header {channel, length-1} does not fit in DATA_W");
    end

    tx_arb_state_t   state_q, state_d;
    logic [CH_W-1:0] cur_q, cur_d;
    logic [CH_W-1:0] last_q, last_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CH_N-1:0] gnt_q, gnt_d;

    logic [CH_N-1:0] arb_gnt;
    logic [CH_W-1:0] arb_idx;
    logic            beat;

    rr_arbiter #(.CH_N(CH_N), .CH_W(CH_W)) u_rr (
        .req     (ch_req),
        .last_ch (last_q),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        rem_d       = rem_q;
        gnt_d       = gnt_q;
        ch_ready    = '0;
        txfifo_wr   = 1'b0;
        txfifo_data = '0;
        beat        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|ch_req) begin
                    cur_d   = arb_idx;
                    rem_d   = ch_len[arb_idx*LEN_W +: LEN_W];
                    gnt_d   = arb_gnt;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                txfifo_wr = !txfifo_full;
                if (!txfifo_full) begin
                    txfifo_data = DATA_W'(hdr_pack(32'(cur_q), 32'(rem_q), CH_W, LEN_W));
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                ch_ready[cur_q] = !txfifo_full;
                beat            = ch_valid[cur_q] && !txfifo_full;
                if (beat) begin
                    txfifo_wr   = 1'b1;
                    txfifo_data = ch_data[cur_q*DATA_W +: DATA_W];
                    if (rem_q == '0) begin
                        last_d  = cur_q;
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge fifo_clk) begin
        if (!fifo_rstn) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            last_q  <= CH_W'(CH_N - 1);
            rem_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            gnt_q   <= gnt_d;
        end
    end

    assign ch_gnt = gnt_q;
    assign cur_ch = cur_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_proto245_tx_arb.sv
// tb/tb_proto245_tx_arb.sv - self-checking bench for proto245_tx_arb
module tb_proto245_tx_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  ch_req, ch_valid, ch_ready, ch_gnt;
    logic [15:0] ch_len;
    logic [31:0] ch_data;
    logic [7:0]  txfifo_data;
    logic        txfifo_wr, txfifo_full, busy;
    logic [1:0]  cur_ch;

    always #5 clk = ~clk;

    proto245_tx_arb #(.CH_N(4), .DATA_W(8), .LEN_W(4)) dut (
        .fifo_clk    (clk),
        .fifo_rstn   (rstn),
        .ch_req      (ch_req),
        .ch_len      (ch_len),
        .ch_data     (ch_data),
        .ch_valid    (ch_valid),
        .ch_ready    (ch_ready),
        .ch_gnt      (ch_gnt),
        .txfifo_data (txfifo_data),
        .txfifo_wr   (txfifo_wr),
        .txfifo_full (txfifo_full),
        .busy        (busy),
        .cur_ch      (cur_ch)
    );

    int checks = 0;
    int failures = 0;

    bit         model_en = 1'b0;
    int         m_mode = 0;
    int         m_ch = 0, m_len = 0, m_left = 0, m_last = 3;
    int         seq [4] = '{0, 0, 0, 0};
    logic [7:0] wr_log [$];

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [3:0] len;
        logic [3:0] valid;
        logic       full;
        logic [7:0] d;
        logic       exp_wr;
        logic [7:0] exp_data;
        logic [3:0] exp_gnt;
        logic       exp_busy;
        logic [3:0] exp_ready;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++)
            if (req[(last + k) % 4]) return (last + k) % 4;
        return 0;
    endfunction

    function automatic logic [7:0] pat(input int c, input int s);
        return 8'(c * 64 + (s % 64));
    endfunction

    // Stream-level reference: idle -> one header -> len+1 payload words, round-robin choice.
    task automatic tick();
        #1;
        if (model_en) begin
            chk("no_wr_while_full", 32'(txfifo_wr & txfifo_full), 0);
            if (!txfifo_wr) chk("data_zero_when_no_wr", 32'(txfifo_data), 0);
            case (m_mode)
                0: begin
                    chk("idle_busy", 32'(busy), 0);
                    chk("idle_gnt", 32'(ch_gnt), 0);
                    chk("idle_wr", 32'(txfifo_wr), 0);
                    chk("idle_ready", 32'(ch_ready), 0);
                    if (|ch_req) begin
                        m_ch   = rr_pick(ch_req, m_last);
                        m_len  = int'(ch_len[m_ch*4 +: 4]);
                        m_mode = 1;
                    end
                end
                1: begin
                    chk("hdr_busy", 32'(busy), 1);
                    chk("hdr_gnt", 32'(ch_gnt), 32'(1 << m_ch));
                    chk("hdr_cur_ch", 32'(cur_ch), 32'(m_ch));
                    chk("hdr_ready", 32'(ch_ready), 0);
                    chk("hdr_wr", 32'(txfifo_wr), 32'(!txfifo_full));
                    if (txfifo_wr) begin
                        chk("hdr_word", 32'(txfifo_data), 32'(m_ch * 16 + m_len));
                        m_left = m_len + 1;
                        m_mode = 2;
                    end
                end
                default: begin
                    chk("data_busy", 32'(busy), 1);
                    chk("data_gnt", 32'(ch_gnt), 32'(1 << m_ch));
                    chk("data_ready", 32'(ch_ready), txfifo_full ? 0 : 32'(1 << m_ch));
                    chk("data_wr", 32'(txfifo_wr), 32'(ch_valid[m_ch] && !txfifo_full));
                    if (ch_valid[m_ch] && !txfifo_full) begin
                        chk("data_word", 32'(txfifo_data), 32'(ch_data[m_ch*8 +: 8]));
                        m_left--;
                        if (m_left == 0) begin
                            m_last = m_ch;
                            m_mode = 0;
                        end
                    end
                end
            endcase
        end
        if (txfifo_wr) wr_log.push_back(txfifo_data);
        for (int c = 0; c < 4; c++)
            if (ch_valid[c] && ch_ready[c]) seq[c]++;
        if (!rstn) begin
            m_mode = 0;
            m_last = 3;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        ch_req = '0;
        ch_valid = '0;
        txfifo_full = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic drive_data();
        for (int c = 0; c < 4; c++) ch_data[c*8 +: 8] = pat(c, seq[c]);
    endtask

    vec_t tbl [18];
    logic [7:0] exp9 [9];
    int base;

    initial begin
        rstn = 1'b0; ch_req = '0; ch_len = '0; ch_data = '0; ch_valid = '0; txfifo_full = 1'b0;
        @(negedge clk);
        do_reset();
        model_en = 1'b1;
        #1;
        chk("rst_gnt", 32'(ch_gnt), 0);
        chk("rst_ready", 32'(ch_ready), 0);
        chk("rst_wr", 32'(txfifo_wr), 0);
        chk("rst_data", 32'(txfifo_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cur_ch", 32'(cur_ch), 0);

        // rst, req, len, valid, full, d, exp_wr, exp_data, exp_gnt, exp_busy, exp_ready
        tbl[0]  = '{1'b1, 4'b0100, 4'd2, 4'b0100, 1'b0, 8'hA1, 1'b0, 8'h00, 4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{1'b0, 4'b0000, 4'd2, 4'b0100, 1'b0, 8'hA1, 1'b1, 8'h22, 4'b0100, 1'b1, 4'b0000};
        tbl[2]  = '{1'b0, 4'b0000, 4'd2, 4'b0100, 1'b0, 8'hA1, 1'b1, 8'hA1, 4'b0100, 1'b1, 4'b0100};
        tbl[3]  = '{1'b0, 4'b0000, 4'd2, 4'b0100, 1'b0, 8'hA2, 1'b1, 8'hA2, 4'b0100, 1'b1, 4'b0100};
        tbl[4]  = '{1'b0, 4'b0000, 4'd2, 4'b0100, 1'b0, 8'hA3, 1'b1, 8'hA3, 4'b0100, 1'b1, 4'b0100};
        tbl[5]  = '{1'b0, 4'b0000, 4'd2, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 4'b0000, 1'b0, 4'b0000};
        tbl[6]  = '{1'b1, 4'b0001, 4'd3, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 4'b0000, 1'b0, 4'b0000};
        tbl[7]  = '{1'b0, 4'b0000, 4'd3, 4'b0001, 1'b0, 8'hB0, 1'b1, 8'h03, 4'b0001, 1'b1, 4'b0000};
        tbl[8]  = '{1'b0, 4'b0000, 4'd3, 4'b0001, 1'b0, 8'hB0, 1'b1, 8'hB0, 4'b0001, 1'b1, 4'b0001};
        tbl[9]  = '{1'b0, 4'b0000, 4'd3, 4'b0001, 1'b0, 8'hB1, 1'b1, 8'hB1, 4'b0001, 1'b1, 4'b0001};
        for (int i = 10; i < 15; i++)
            tbl[i] = '{1'b0, 4'b0000, 4'd3, 4'b0001, 1'b1, 8'hB2, 1'b0, 8'h00, 4'b0001, 1'b1, 4'b0000};
        tbl[15] = '{1'b0, 4'b0000, 4'd3, 4'b0001, 1'b0, 8'hB2, 1'b1, 8'hB2, 4'b0001, 1'b1, 4'b0001};
        tbl[16] = '{1'b0, 4'b0000, 4'd3, 4'b0001, 1'b0, 8'hB3, 1'b1, 8'hB3, 4'b0001, 1'b1, 4'b0001};
        tbl[17] = '{1'b0, 4'b0000, 4'd3, 4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 4'b0000, 1'b0, 4'b0000};

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rst) begin
                do_reset();
                wr_log.delete();
            end
            ch_req = tbl[i].req;
            ch_len = {4{tbl[i].len}};
            ch_valid = tbl[i].valid;
            txfifo_full = tbl[i].full;
            ch_data = {4{tbl[i].d}};
            #1;
            chk($sformatf("vec%0d_wr", i), 32'(txfifo_wr), 32'(tbl[i].exp_wr));
            chk($sformatf("vec%0d_data", i), 32'(txfifo_data), 32'(tbl[i].exp_data));
            chk($sformatf("vec%0d_gnt", i), 32'(ch_gnt), 32'(tbl[i].exp_gnt));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            chk($sformatf("vec%0d_ready", i), 32'(ch_ready), 32'(tbl[i].exp_ready));
            tick();
        end
        chk("backpressure_write_count", 32'(wr_log.size()), 5);

        // All four requesting with len=0: strict rotation 0,1,2,3 then back to 0.
        do_reset();
        wr_log.delete();
        ch_req = 4'b1111; ch_len = '0; ch_valid = 4'b1111;
        ch_data = {8'h53, 8'h52, 8'h51, 8'h50};
        exp9 = '{8'h00, 8'h50, 8'h10, 8'h51, 8'h20, 8'h52, 8'h30, 8'h53, 8'h00};
        for (int t = 0; t < 40 && wr_log.size() < 9; t++) tick();
        chk("allfour_write_count", 32'(wr_log.size() >= 9), 1);
        if (wr_log.size() >= 9)
            for (int i = 0; i < 9; i++) chk($sformatf("allfour_word%0d", i), 32'(wr_log[i]), 32'(exp9[i]));

        // Single-cycle request pulse, len=15, toggling valid: header plus 16 words.
        do_reset();
        wr_log.delete();
        base = seq[1];
        ch_req = 4'b0010; ch_len = {4{4'd15}}; ch_valid = 4'b0000; drive_data();
        tick();
        ch_req = '0; ch_len = '0;
        for (int t = 0; t < 120; t++) begin
            ch_valid = {2'b00, t[0], 1'b0};
            drive_data();
            tick();
        end
        chk("pulse_write_count", 32'(wr_log.size()), 17);
        if (wr_log.size() == 17) begin
            chk("pulse_header", 32'(wr_log[0]), 32'h1F);
            for (int i = 1; i < 17; i++)
                chk($sformatf("pulse_word%0d", i), 32'(wr_log[i]), 32'(pat(1, base + i - 1)));
        end

        // Reset after two data beats of a len=7 burst, then channel 0 wins over channel 3.
        do_reset();
        ch_req = 4'b0010; ch_len = {4{4'd7}}; ch_valid = 4'b0010; drive_data();
        tick();
        ch_req = '0;
        for (int t = 0; t < 3; t++) begin
            drive_data();
            tick();
        end
        chk("midrst_busy_before", 32'(busy), 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1; ch_valid = '0; ch_req = '0;
        #1;
        chk("midrst_gnt", 32'(ch_gnt), 0);
        chk("midrst_ready", 32'(ch_ready), 0);
        chk("midrst_wr", 32'(txfifo_wr), 0);
        chk("midrst_data", 32'(txfifo_data), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_cur_ch", 32'(cur_ch), 0);
        tick();
        ch_req = 4'b1001; ch_len = {4{4'd1}};
        tick();
        #1;
        chk("midrst_regrant_ch", 32'(cur_ch), 0);
        chk("midrst_regrant_gnt", 32'(ch_gnt), 32'h1);
        tick();

        // Random stress against the stream-level reference.
        do_reset();
        for (int t = 0; t < 10000; t++) begin
            for (int c = 0; c < 4; c++) begin
                ch_req[c]   = ($urandom % 3) == 0;
                ch_valid[c] = ($urandom % 4) != 0;
            end
            ch_len = 16'($urandom);
            txfifo_full = ($urandom % 5) == 0;
            drive_data();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
